fpu_result_buffer: RTL and testbench

// - Sits directly downstream of the PE's fixed-latency FP16 FPU pipeline, which cannot stall.
// - Captures every valid result (status != 2'b00) into a FIFO and re-presents it on a valid/ready port to the PE writeback.
// - Tracks ops in flight and grants issue credits upstream, so no result is dropped when the consumer back-pressures.

---
 rtl/pe_fpu_pkg.sv | 14 +
 rtl/pe_sync_fifo.sv | 55 +++++
 rtl/fpu_result_buffer.sv | 105 ++++++++++
 tb/tb_fpu_result_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_fpu_pkg.sv
// Shared PE/FPU types: FP16 payload, FPU status tag and the captured result bundle.
package pe_fpu_pkg;

    typedef logic [15:0] fp16_t;
    typedef logic [1:0]  fpu_tag_t;

    localparam fpu_tag_t FPU_TAG_NONE = 2'b00;

    typedef struct packed {
        fpu_tag_t tag;
        fp16_t    data;
    } fpu_result_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// Register-array synchronous FIFO with occupancy count; head read straight from the array.
module pe_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_fire = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fpu_result_buffer.sv
// Result buffer behind the non-stallable FPU: captures every valid result,
// re-presents it on valid/ready and hands out issue credits so nothing is lost.
module fpu_result_buffer
    import pe_fpu_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FPU_LATENCY = 3,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_i,
    input  fp16_t         fpu_result_i,
    input  fpu_tag_t      fpu_status_i,
    input  logic          fpu_empty_i,
    output logic          issue_ok_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output fp16_t         out_data_o,
    output fpu_tag_t      out_tag_o,
    output logic [CW-1:0] count_o,
    output logic          idle_o,
    output logic          err_o
);

    localparam logic [CW-1:0] INFLIGHT_MAX = '1;

    fpu_result_t   wr_entry;
    fpu_result_t   head;
    logic          capture;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] inflight;
    logic [CW:0]   committed;
    logic          err_set;

    assign capture  = (fpu_status_i != FPU_TAG_NONE);
    assign wr_entry = '{tag: fpu_status_i, data: fpu_result_i};

    pe_sync_fifo #(
        .WIDTH ($bits(fpu_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (wr_entry),
        .rd_en   (out_ready_i),
        .rd_data (head),
        .count   (count_o),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid_o = !empty;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = head.data;
    assign out_tag_o   = head.tag;

    // Credits cover both stored results and results still inside the FPU.
    assign committed  = (CW + 1)'(count_o) + (CW + 1)'(inflight);
    assign issue_ok_o = (committed < (CW + 1)'(DEPTH));
    assign idle_o     = empty && (inflight == '0) && fpu_empty_i;

    assign err_set = (issue_i && !issue_ok_o)
                   || (capture && full && !pop)
                   || (capture && (inflight == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
            err_o    <= 1'b0;
        end else begin
            case ({issue_i, capture})
                2'b10: begin
                    if (inflight != INFLIGHT_MAX)
                        inflight <= inflight + 1'b1;
                end
                2'b01: begin
                    if (inflight != '0)
                        inflight <= inflight - 1'b1;
                end
                default: inflight <= inflight;
            endcase
            if (err_set)
                err_o <= 1'b1;
        end
    end

    if (FPU_LATENCY < 1) begin : g_bad_latency
        $error("fpu_result_buffer: FPU_LATENCY must be at least 1");
    end

    a_credit_bound: assert property (
        @(posedge clk) disable iff (reset || err_o)
        committed <= (CW + 1)'(DEPTH)
    );

    a_head_tag: assert property (
        @(posedge clk) disable iff (reset)
        out_valid_o |-> (out_tag_o != FPU_TAG_NONE)
    );

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Randomized and directed bench for fpu_result_buffer with a queue-based reference
// model and a fixed-latency FPU stand-in.
module tb_fpu_result_buffer;
    import pe_fpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_i;
    fp16_t       fpu_result_i;
    fpu_tag_t    fpu_status_i;
    logic        fpu_empty_i;
    logic        issue_ok_o;
    logic        out_valid_o;
    logic        out_ready_i;
    fp16_t       out_data_o;
    fpu_tag_t    out_tag_o;
    logic [3:0]  count_o;
    logic        idle_o;
    logic        err_o;

    always #5 clk = ~clk;

    fpu_result_buffer #(.DEPTH(DEPTH), .FPU_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_i      (issue_i),
        .fpu_result_i (fpu_result_i),
        .fpu_status_i (fpu_status_i),
        .fpu_empty_i  (fpu_empty_i),
        .issue_ok_o   (issue_ok_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_tag_o    (out_tag_o),
        .count_o      (count_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    fpu_result_t mq[$];
    int          m_inflight = 0;
    bit          m_err      = 0;
    fpu_result_t pipe[LAT];

    bit          d_reset = 1;
    bit          d_force = 0;
    fpu_result_t d_force_v;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic fpu_result_t mk(input logic [1:0] tag, input logic [15:0] data);
        fpu_result_t r;
        r.tag  = tag;
        r.data = data;
        return r;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance model and FPU.
    task automatic step(input bit iss, input bit rdy, input fpu_result_t op_in);
        fpu_result_t cap_v;
        fpu_result_t op;
        bit          pipe_empty;
        bit          ok;
        bit          pop;
        bit          cap;
        int          sz;
        op = op_in;
        if (op.tag == 2'b00)
            op = mk(2'($urandom_range(1, 3)), 16'($urandom));
        cap_v = d_force ? d_force_v : pipe[LAT-1];
        pipe_empty = 1;
        foreach (pipe[i])
            if (pipe[i].tag != 2'b00)
                pipe_empty = 0;
        reset        = d_reset;
        issue_i      = iss;
        out_ready_i  = rdy;
        fpu_status_i = cap_v.tag;
        fpu_result_i = cap_v.data;
        fpu_empty_i  = pipe_empty;
        #1;
        chk("out_valid", int'(out_valid_o), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", int'(out_data_o), int'(mq[0].data));
            chk("out_tag", int'(out_tag_o), int'(mq[0].tag));
        end
        chk("count", int'(count_o), mq.size());
        chk("issue_ok", int'(issue_ok_o), int'((mq.size() + m_inflight) < DEPTH));
        chk("idle", int'(idle_o), int'(mq.size() == 0 && m_inflight == 0 && pipe_empty));
        chk("err", int'(err_o), int'(m_err));
        if (d_reset) begin
            mq.delete();
            m_inflight = 0;
            m_err = 0;
            foreach (pipe[i])
                pipe[i] = '0;
        end else begin
            ok  = (mq.size() + m_inflight) < DEPTH;
            pop = (mq.size() > 0) && rdy;
            cap = (cap_v.tag != 2'b00);
            if (iss && !ok)
                m_err = 1;
            if (cap && m_inflight == 0)
                m_err = 1;
            if (cap && mq.size() == DEPTH && !pop)
                m_err = 1;
            sz = mq.size();
            if (pop)
                void'(mq.pop_front());
            if (cap && (sz < DEPTH || pop))
                mq.push_back(cap_v);
            if (iss && !cap)
                m_inflight = (m_inflight < 15) ? m_inflight + 1 : 15;
            else if (cap && !iss && m_inflight > 0)
                m_inflight = m_inflight - 1;
            for (int i = LAT - 1; i > 0; i--)
                pipe[i] = pipe[i-1];
            pipe[0] = iss ? op : '0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        d_force = 0;
    endtask

    task automatic do_reset();
        d_reset = 1;
        step(0, 0, '0);
        d_reset = 0;
    endtask

    initial begin
        int c0;
        int acc;
        int nvalid;
        int first;
        int last;
        int expv;
        int maxc;
        bit inorder;
        bit iss;

        foreach (pipe[i])
            pipe[i] = '0;
        reset = 1; issue_i = 0; out_ready_i = 0;
        fpu_status_i = '0; fpu_result_i = '0; fpu_empty_i = 1;
        @(negedge clk);
        d_reset = 1;
        step(0, 0, '0);
        step(0, 0, '0);
        d_reset = 0;
        chk("rst_issue_ok", int'(issue_ok_o), 1);
        chk("rst_count", int'(count_o), 0);
        chk("rst_valid", int'(out_valid_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_idle", int'(idle_o), 1);

        // single op latency
        c0 = cyc;
        step(1, 0, mk(2'b01, 16'h3C00));
        for (int k = 0; k < 10 && !out_valid_o; k++)
            step(0, 0, '0);
        chk("t1_latency", cyc - c0, 4);
        chk("t1_data", int'(out_data_o), 16'h3C00);
        chk("t1_tag", int'(out_tag_o), 1);
        step(0, 1, '0);
        step(0, 0, '0);
        chk("t1_idle", int'(idle_o), 1);

        // fill against a stalled consumer
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            iss = issue_ok_o;
            acc += int'(iss);
            step(iss, 0, '0);
        end
        for (int k = 0; k < 5; k++)
            step(0, 0, '0);
        chk("t2_issues", acc, 8);
        chk("t2_issue_ok", int'(issue_ok_o), 0);
        chk("t2_count", int'(count_o), 8);
        chk("t2_err", int'(err_o), 0);

        // one pop frees exactly one credit
        step(0, 1, '0);
        chk("t3_ok_n1", int'(issue_ok_o), 1);
        step(1, 0, '0);
        chk("t3_ok_n2", int'(issue_ok_o), 0);
        for (int k = 0; k < 5; k++)
            step(0, 0, '0);
        chk("t3_count", int'(count_o), 8);
        chk("t3_err", int'(err_o), 0);

        // streaming
        do_reset();
        nvalid = 0; first = -1; last = -1; expv = 1; maxc = 0; inorder = 1;
        for (int k = 0; k < 30; k++) begin
            if (out_valid_o) begin
                if (first < 0)
                    first = cyc;
                last = cyc;
                nvalid++;
                if (int'(out_data_o) != expv)
                    inorder = 0;
                expv++;
            end
            if (int'(count_o) > maxc)
                maxc = int'(count_o);
            step(k < 20, 1, mk(2'b01, 16'(k + 1)));
        end
        chk("t4_nvalid", nvalid, 20);
        chk("t4_no_bubble", last - first, 19);
        chk("t4_in_order", int'(inorder), 1);
        chk("t4_max_count", maxc, 1);

        // capture with nothing in flight
        do_reset();
        d_force = 1;
        d_force_v = mk(2'b10, 16'h1234);
        step(0, 0, '0);
        chk("t5_err_orphan", int'(err_o), 1);
        for (int k = 0; k < 4; k++)
            step(0, 0, '0);
        chk("t5_err_sticky", int'(err_o), 1);
        do_reset();
        chk("t5_err_cleared", int'(err_o), 0);

        // issue without credit
        for (int k = 0; k < 12; k++)
            step(issue_ok_o, 0, '0);
        for (int k = 0; k < 5; k++)
            step(0, 0, '0);
        chk("t5_pre_err", int'(err_o), 0);
        step(1, 0, '0);
        chk("t5_err_overissue", int'(err_o), 1);
        for (int k = 0; k < 5; k++)
            step(0, 0, '0);
        chk("t5_err_hold", int'(err_o), 1);
        chk("t5_count_full", int'(count_o), 8);

        // reset mid-operation
        do_reset();
        for (int k = 0; k < 7; k++)
            step(1, 0, '0);
        for (int k = 0; k < 10 && mq.size() < 5; k++)
            step(0, 0, '0);
        chk("t6_stored", int'(count_o), 5);
        chk("t6_model_inflight", m_inflight, 2);
        do_reset();
        chk("t6_count", int'(count_o), 0);
        chk("t6_valid", int'(out_valid_o), 0);
        chk("t6_issue_ok", int'(issue_ok_o), 1);
        chk("t6_err", int'(err_o), 0);

        // random traffic
        for (int k = 0; k < 3000; k++)
            step(issue_ok_o && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0, '0);
        for (int k = 0; k < 15; k++)
            step(0, 1, '0);
        chk("rand_idle", int'(idle_o), 1);
        chk("rand_err", int'(err_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
